// File: rtl/bin2bcd_seq_amisha_if.sv
// Handshake and result bundle between a conversion requester and the
// sequential binary-to-BCD converter.
interface bin2bcd_seq_amisha_if #(
    parameter int N = 13
);
    logic         start_amisha;
    logic [N-1:0] bin_amisha;
    logic         ready_amisha;
    logic         done_tick_amisha;
    logic [3:0]   bcd3_amisha;
    logic [3:0]   bcd2_amisha;
    logic [3:0]   bcd1_amisha;
    logic [3:0]   bcd0_amisha;

    modport master (
        output start_amisha, bin_amisha,
        input  ready_amisha, done_tick_amisha,
        input  bcd3_amisha, bcd2_amisha, bcd1_amisha, bcd0_amisha
    );

    modport slave (
        input  start_amisha, bin_amisha,
        output ready_amisha, done_tick_amisha,
        output bcd3_amisha, bcd2_amisha, bcd1_amisha, bcd0_amisha
    );
endinterface

// File: rtl/bin2bcd_seq_amisha.sv
// Sequential double-dabble converter: one shift per clock, results land in
// output registers only when the conversion completes.
module bin2bcd_seq_amisha #(
    parameter int N = 13
) (
    input  logic                    clk_amisha,
    input  logic                    reset_amisha,
    bin2bcd_seq_amisha_if.slave     bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OP   = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [N-1:0]  bin_shift_reg, bin_shift_next;
    logic [15:0]   bcd_work_reg, bcd_work_next;
    logic [15:0]   bcd_out_reg, bcd_out_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [15:0]   bcd_adj;
    logic [15+N:0] shifted;

    // Add-3 correction per digit; a digit of at most 9 never exceeds 12, so no carry out.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_work_reg[gi*4 +: 4] > 4'd4)
                                      ? bcd_work_reg[gi*4 +: 4] + 4'd3
                                      : bcd_work_reg[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {bcd_adj, bin_shift_reg} << 1;

    always_comb begin
        state_next     = state_reg;
        bin_shift_next = bin_shift_reg;
        bcd_work_next  = bcd_work_reg;
        bcd_out_next   = bcd_out_reg;
        cnt_next       = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start_amisha) begin
                    bin_shift_next = bus.bin_amisha;
                    bcd_work_next  = '0;
                    cnt_next       = 4'(N);
                    state_next     = OP;
                end
            end
            OP: begin
                bin_shift_next = shifted[N-1:0];
                bcd_work_next  = shifted[15+N:N];
                cnt_next       = cnt_reg - 4'd1;
                // Last shift: publish the finished digits on the same edge that enters DONE.
                if (cnt_reg == 4'd1) begin
                    bcd_out_next = shifted[15+N:N];
                    state_next   = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state_reg     <= IDLE;
            bin_shift_reg <= '0;
            bcd_work_reg  <= '0;
            bcd_out_reg   <= '0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            bin_shift_reg <= bin_shift_next;
            bcd_work_reg  <= bcd_work_next;
            bcd_out_reg   <= bcd_out_next;
            cnt_reg       <= cnt_next;
        end
    end

    assign bus.ready_amisha     = (state_reg == IDLE);
    assign bus.done_tick_amisha = (state_reg == DONE);
    assign bus.bcd3_amisha      = bcd_out_reg[15:12];
    assign bus.bcd2_amisha      = bcd_out_reg[11:8];
    assign bus.bcd1_amisha      = bcd_out_reg[7:4];
    assign bus.bcd0_amisha      = bcd_out_reg[3:0];
endmodule

// File: tb/tb_bin2bcd_seq_amisha.sv
// Directed bench for bin2bcd_seq_amisha: a 13-bit and an 8-bit instance
// share clock and reset; expected digits are written in hex-as-decimal.
module tb_bin2bcd_seq_amisha;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_amisha_if #(.N(13)) ia ();
    bin2bcd_seq_amisha_if #(.N(8))  ib ();

    bin2bcd_seq_amisha #(.N(13)) dut_a (
        .clk_amisha   (clk),
        .reset_amisha (rst),
        .bus          (ia.slave)
    );

    bin2bcd_seq_amisha #(.N(8)) dut_b (
        .clk_amisha   (clk),
        .reset_amisha (rst),
        .bus          (ib.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] obs_bcd(input int which);
        if (which != 0)
            return {ib.bcd3_amisha, ib.bcd2_amisha, ib.bcd1_amisha, ib.bcd0_amisha};
        return {ia.bcd3_amisha, ia.bcd2_amisha, ia.bcd1_amisha, ia.bcd0_amisha};
    endfunction

    function automatic logic obs_done(input int which);
        return (which != 0) ? ib.done_tick_amisha : ia.done_tick_amisha;
    endfunction

    function automatic logic obs_ready(input int which);
        return (which != 0) ? ib.ready_amisha : ia.ready_amisha;
    endfunction

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic digits_ok(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    task automatic drive(input int which, input logic s, input logic [12:0] b);
        if (which != 0) begin
            ib.start_amisha = s;
            ib.bin_amisha   = b[7:0];
        end else begin
            ia.start_amisha = s;
            ia.bin_amisha   = b;
        end
    endtask

    // Called 1ns after a posedge with the DUT idle; returns 1ns after the cycle following done.
    task automatic conv(input int which, input logic [12:0] b, input logic [15:0] prev,
                        input logic [15:0] exp, input bit disturb, input string tag);
        int n;
        int cyc;
        bit hold_ok;
        n = (which != 0) ? 8 : 13;
        drive(which, 1'b1, b);
        @(posedge clk); #1;
        drive(which, 1'b0, ~b);
        cyc = 0;
        hold_ok = 1'b1;
        while (!obs_done(which) && cyc < 40) begin
            if (obs_bcd(which) !== prev || obs_ready(which) !== 1'b0) hold_ok = 1'b0;
            if (disturb && cyc == 4) drive(which, 1'b1, 13'd7);
            if (disturb && cyc == 5) drive(which, 1'b0, 13'd42);
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(n));
        check({tag, "_bcd"}, 32'(obs_bcd(which)), 32'(exp));
        check({tag, "_digits"}, 32'(digits_ok(obs_bcd(which))), 32'd1);
        check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        @(posedge clk); #1;
        check({tag, "_ready_after"}, 32'(obs_ready(which)), 32'd1);
        check({tag, "_done_after"}, 32'(obs_done(which)), 32'd0);
        $display("conv %s: dut=%0d bin=%0d bcd=%h cycles=%0d", tag, which, b, obs_bcd(which), cyc);
    endtask

    task automatic quiet(input int which, input int cycles, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (obs_done(which) !== 1'b0) seen = 1'b1;
        end
        check({tag, "_no_done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        int last;
        int t;
        int rdy_cnt;
        int ticks;
        logic [15:0] prev;

        rst = 1'b1;
        drive(0, 1'b0, 13'd0);
        drive(1, 1'b0, 13'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        check("reset_ready_a", 32'(ia.ready_amisha), 32'd1);
        check("reset_done_a", 32'(ia.done_tick_amisha), 32'd0);
        check("reset_bcd_a", 32'(obs_bcd(0)), 32'h0000);
        check("reset_ready_b", 32'(ib.ready_amisha), 32'd1);
        check("reset_bcd_b", 32'(obs_bcd(1)), 32'h0000);

        conv(0, 13'd0,    16'h0000, 16'h0000, 1'b0, "zero");
        conv(0, 13'd8191, 16'h0000, 16'h8191, 1'b0, "max8191");
        conv(0, 13'd1234, 16'h8191, 16'h1234, 1'b0, "v1234");
        conv(0, 13'd4095, 16'h1234, 16'h4095, 1'b0, "v4095");

        conv(0, 13'd1000, 16'h4095, 16'h1000, 1'b1, "ignore_start");
        quiet(0, 20, "ignore_start");

        // Start held high: one conversion every N+2 cycles.
        drive(0, 1'b1, 13'd9);
        last = -1;
        rdy_cnt = 0;
        ticks = 0;
        for (t = 1; t <= 60; t++) begin
            @(posedge clk); #1;
            if (ia.ready_amisha) rdy_cnt++;
            if (ia.done_tick_amisha) begin
                ticks++;
                check("b2b_bcd", 32'(obs_bcd(0)), 32'h0009);
                if (last >= 0) begin
                    check("b2b_period", 32'(t - last), 32'd15);
                    check("b2b_ready_pulse", 32'(rdy_cnt), 32'd1);
                end
                $display("b2b tick %0d at cycle %0d bcd=%h", ticks, t, obs_bcd(0));
                rdy_cnt = 0;
                last = t;
            end
        end
        drive(0, 1'b0, 13'd9);
        check("b2b_ticks", 32'(ticks), 32'd4);
        @(posedge clk); #1;

        // Asynchronous reset mid-conversion.
        drive(0, 1'b1, 13'd5555);
        @(posedge clk); #1;
        drive(0, 1'b0, 13'd5555);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_bcd", 32'(obs_bcd(0)), 32'h0000);
        check("arst_ready", 32'(ia.ready_amisha), 32'd1);
        check("arst_done", 32'(ia.done_tick_amisha), 32'd0);
        $display("async reset applied: bcd=%h ready=%0d", obs_bcd(0), ia.ready_amisha);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        quiet(0, 20, "arst");
        conv(0, 13'd5555, 16'h0000, 16'h5555, 1'b0, "v5555");

        conv(1, 13'd255, 16'h0000, 16'h0255, 1'b0, "n8_255");
        prev = 16'h0255;
        for (int v = 0; v < 256; v++) begin
            conv(1, 13'(v), prev, ref_bcd(v), 1'b0, "n8_sweep");
            prev = ref_bcd(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
